// File: rtl/mvm_stream_ctrl.sv
// Byte-stream operand sequencer for the 3x3 matrix-vector datapath; MVM_CTRL_MATRIX_REUSE_EN adds vector-only frames.
// Results captured MVM_LAT+1 edges after the last byte; in_ready low in WAIT/OUT, out_ready low holds the word.
module mvm_stream_ctrl #(
  parameter int DW      = 8,
  parameter int RW      = 16,
  parameter int MVM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RW-1:0]     out_data,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic [9*DW-1:0]   mat_o,
  output logic [3*DW-1:0]   vec_o,
  input  logic [3*RW-1:0]   res_i,
  output logic              busy
`ifdef MVM_CTRL_MATRIX_REUSE_EN
  ,
  input  logic              in_vec_only
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_OUT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_idx;
  logic [3:0]        r_cnt;
  logic [1:0]        r_oidx;
  logic [RW-1:0]     r_res [3];
  logic [9*DW-1:0]   r_mat;
  logic [3*DW-1:0]   r_vec;
  logic              w_in_acc;
  logic              w_out_acc;
  logic              w_vec_only;
  logic              w_load_done;
  logic [3:0]        w_wr_idx;

`ifdef MVM_CTRL_MATRIX_REUSE_EN
  logic r_mat_loaded;
  assign w_vec_only = in_vec_only & r_mat_loaded;
`else
  assign w_vec_only = 1'b0;
`endif

  assign w_in_acc    = in_valid & in_ready;
  assign w_out_acc   = out_valid & out_ready;
  // A vector-only frame starts writing at v0 instead of m00.
  assign w_wr_idx    = (r_state == S_IDLE && w_vec_only) ? 4'd9 : r_idx;
  assign w_load_done = w_in_acc && (w_wr_idx == 4'd11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_in_acc)                      w_next = S_LOAD;
      S_LOAD: if (w_load_done)                   w_next = S_WAIT;
      S_WAIT: if (r_cnt == 4'd0)                 w_next = S_OUT;
      S_OUT:  if (w_out_acc && r_oidx == 2'd2)   w_next = S_IDLE;
      default:                                   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = ~rst & (r_state == S_IDLE || r_state == S_LOAD);
    out_valid = (r_state == S_OUT);
    busy      = (r_state != S_IDLE);
    out_last  = (r_state == S_OUT) && (r_oidx == 2'd2);
    out_idx   = r_oidx;
    out_data  = '0;
    if (r_state == S_OUT) begin
      case (r_oidx)
        2'd0:    out_data = r_res[0];
        2'd1:    out_data = r_res[1];
        default: out_data = r_res[2];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_oidx <= '0;
      r_mat  <= '0;
      r_vec  <= '0;
      for (int i = 0; i < 3; i++) r_res[i] <= '0;
    end else begin
      if (w_in_acc) begin
        for (int k = 0; k < 9; k++)
          if (w_wr_idx == 4'(k)) r_mat[k*DW +: DW] <= in_data;
        for (int k = 0; k < 3; k++)
          if (w_wr_idx == 4'(k + 9)) r_vec[k*DW +: DW] <= in_data;
        r_idx <= w_load_done ? 4'd0 : w_wr_idx + 4'd1;
      end
      if (w_load_done)
        r_cnt <= 4'(MVM_LAT);
      else if (r_state == S_WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (r_state == S_WAIT && r_cnt == 4'd0)
        for (int i = 0; i < 3; i++) r_res[i] <= res_i[i*RW +: RW];
      if (w_out_acc)
        r_oidx <= (r_oidx == 2'd2) ? 2'd0 : r_oidx + 2'd1;
    end
  end

`ifdef MVM_CTRL_MATRIX_REUSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_mat_loaded <= 1'b0;
    else if (w_load_done) r_mat_loaded <= 1'b1;
  end
`endif

  assign mat_o = r_mat;
  assign vec_o = r_vec;

endmodule

// File: tb/tb_mvm_stream_ctrl.sv
// Directed bench for mvm_stream_ctrl with a one-cycle registered datapath stub (MVM_LAT=1).
module tb_mvm_stream_ctrl;
  localparam int DW = 8;
  localparam int RW = 16;
  localparam int LAT = 1;

  logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [DW-1:0] in_data;
  logic [RW-1:0] out_data;
  logic [1:0] out_idx;
  logic [9*DW-1:0] mat_o;
  logic [3*DW-1:0] vec_o;
  logic [3*RW-1:0] res_i;
`ifdef MVM_CTRL_MATRIX_REUSE_EN
  logic in_vec_only;
`endif

  mvm_stream_ctrl #(.DW(DW), .RW(RW), .MVM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .mat_o(mat_o), .vec_o(vec_o), .res_i(res_i), .busy(busy)
`ifdef MVM_CTRL_MATRIX_REUSE_EN
    , .in_vec_only(in_vec_only)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stub: one register stage, wraps modulo 2^RW.
  always @(posedge clk) begin
    for (int r = 0; r < 3; r++) begin
      int acc;
      acc = 0;
      for (int c = 0; c < 3; c++)
        acc += int'(mat_o[(3*r+c)*DW +: DW]) * int'(vec_o[c*DW +: DW]);
      res_i[r*RW +: RW] <= RW'(acc);
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int last_acc = 0;
  logic [7:0] fr_m [9];
  logic [7:0] fr_v [3];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int start, input int max_gap);
    for (int k = start; k < 12; k++)
      send_byte(k < 9 ? fr_m[k] : fr_v[k-9], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic recv_word(input logic [15:0] exp, input logic [1:0] idx, input logic last, input int stall);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    chk("in_ready_blocked", in_ready, 0);
    for (int s = 0; s < stall; s++) begin
      chk("stall_data", out_data, exp);
      chk("stall_idx", out_idx, idx);
      @(negedge clk);
    end
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp);
    chk("out_idx", out_idx, idx);
    chk("out_last", out_last, last);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic recv_frame(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2, input int stall);
    recv_word(e0, 2'd0, 1'b0, stall);
    recv_word(e1, 2'd1, 1'b0, stall);
    recv_word(e2, 2'd2, 1'b1, stall);
    chk("idle_after_frame", {busy, out_valid}, 2'b00);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mat", mat_o, 0);
    chk("rst_vec", vec_o, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    logic [9*DW-1:0] exp_mat;
    int t;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef MVM_CTRL_MATRIX_REUSE_EN
    in_vec_only = 1'b0;
`endif
    #2;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame, no stalls, with latency check.
    fr_m = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    fr_v = '{8'd1, 8'd1, 8'd1};
    send_frame(0, 0);
    chk("wait_busy", busy, 1);
    chk("wait_in_ready", in_ready, 0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("latency_edges", cyc - last_acc, LAT + 1);
    recv_frame(16'd6, 16'd15, 16'd24, 0);
    for (int k = 0; k < 9; k++) exp_mat[k*DW +: DW] = 8'(k + 1);
    chk("mat_hold", mat_o, exp_mat);
    chk("vec_hold", vec_o, 24'h010101);

    // Back-to-back frames.
    fr_m = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
    fr_v = '{8'd2, 8'd3, 8'd4};
    send_frame(0, 0);
    recv_frame(16'd101, 16'd128, 16'd155, 0);
    fr_m = '{8'd3, 8'd6, 8'd9, 8'd2, 8'd4, 8'd8, 8'd1, 8'd7, 8'd5};
    fr_v = '{8'd1, 8'd0, 8'd1};
    send_frame(0, 0);
    recv_frame(16'd12, 16'd10, 16'd6, 0);

    // Input gaps and output stalls.
    fr_m = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    fr_v = '{8'd1, 8'd1, 8'd1};
    send_frame(0, 3);
    recv_frame(16'd6, 16'd15, 16'd24, 5);

    // All-ones operands wrap, no saturation.
    fr_m = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    fr_v = '{8'd255, 8'd255, 8'd255};
    send_frame(0, 0);
    recv_frame(16'd64003, 16'd64003, 16'd64003, 0);

    // Reset mid-frame discards the partial frame.
    fr_m = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    fr_v = '{8'd1, 8'd1, 8'd1};
    for (int k = 0; k < 5; k++) send_byte(8'(50 + k), 0);
    chk("partial_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(0, 0);
    recv_frame(16'd6, 16'd15, 16'd24, 0);

`ifdef MVM_CTRL_MATRIX_REUSE_EN
    // No matrix loaded yet: vec-only request still takes a full frame.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_vec_only = 1'b1;
    send_frame(0, 0);
    recv_frame(16'd6, 16'd15, 16'd24, 0);
    fr_v = '{8'd2, 8'd3, 8'd4};
    send_frame(9, 0);
    recv_frame(16'd20, 16'd47, 16'd74, 0);
    chk("reuse_mat_kept", mat_o, exp_mat);
    in_vec_only = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
